// File: rtl/arb_pkg.sv
// Shared definitions for the 8-way round-robin arbiter: sizes, FSM states
// and the one-hot to binary encoder used by the datapath select.
package arb_pkg;

  localparam int N    = 8;
  localparam int IDXW = 3;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

  // Lowest set bit wins when more than one bit is set.
  function automatic logic [IDXW-1:0] encode8(input logic [N-1:0] vec);
    encode8 = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (vec[i]) encode8 = IDXW'(i);
    end
  endfunction

endpackage

// File: rtl/rr_pick8.sv
// Combinational round-robin pick: first unmasked request at or after ptr,
// wrapping modulo 8.
module rr_pick8
  import arb_pkg::*;
(
  input  logic [N-1:0]    req,
  input  logic [N-1:0]    mask,
  input  logic [IDXW-1:0] ptr,
  output logic            found,
  output logic [IDXW-1:0] idx
);

  logic [N-1:0]    masked;
  logic [N-1:0]    rotated;
  logic [IDXW-1:0] src;
  logic [IDXW-1:0] offset;

  assign masked = req & ~mask;

  // Rotate right by ptr so the highest-priority requester lands on bit 0.
  always_comb begin
    rotated = '0;
    src     = '0;
    for (int i = 0; i < N; i++) begin
      src        = IDXW'(i) + ptr;
      rotated[i] = masked[src];
    end
  end

  assign found  = |masked;
  assign offset = encode8(rotated);
  assign idx    = offset + ptr;

endmodule

// File: rtl/rr_arbiter_8.sv
// Round-robin arbiter for 8 requesters with registered one-hot grant,
// binary index and a hold limit that forces rotation under contention.
module rr_arbiter_8
  import arb_pkg::*;
#(
  parameter int MAX_HOLD = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N-1:0]    req,
  output logic [N-1:0]    gnt,
  output logic [IDXW-1:0] gnt_idx,
  output logic            gnt_valid,
  output logic            preempt
);

  localparam int HW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
  localparam logic [HW-1:0] HOLD_LIM = HW'(MAX_HOLD);
  localparam logic [N-1:0]  ONE_BIT  = N'(1);

  arb_state_e      state, state_n;
  logic [IDXW-1:0] ptr, ptr_n;
  logic [HW-1:0]   hold_cnt, hold_n;
  logic [N-1:0]    gnt_n;
  logic [IDXW-1:0] idx_n;
  logic            valid_n;
  logic            preempt_n;

  logic [IDXW-1:0] pick_ptr;
  logic [N-1:0]    pick_mask;
  logic            pick_found;
  logic [IDXW-1:0] pick_idx;
  logic            holder_req;
  logic            hold_expired;

  // While granted, every pick (release or rotation) starts after the holder
  // and excludes it; from IDLE the stored pointer is used unmasked.
  assign pick_ptr     = (state == GRANT) ? gnt_idx + IDXW'(1) : ptr;
  assign pick_mask    = (state == GRANT) ? gnt : '0;
  assign holder_req   = req[gnt_idx];
  assign hold_expired = (MAX_HOLD != 0) && (hold_cnt == HOLD_LIM);

  rr_pick8 u_pick (
    .req   (req),
    .mask  (pick_mask),
    .ptr   (pick_ptr),
    .found (pick_found),
    .idx   (pick_idx)
  );

  always_comb begin
    state_n   = state;
    ptr_n     = ptr;
    hold_n    = hold_cnt;
    gnt_n     = gnt;
    idx_n     = gnt_idx;
    valid_n   = gnt_valid;
    preempt_n = 1'b0;
    unique case (state)
      IDLE: begin
        if (pick_found) begin
          state_n = GRANT;
          gnt_n   = ONE_BIT << pick_idx;
          idx_n   = pick_idx;
          valid_n = 1'b1;
          hold_n  = HW'(1);
        end
      end
      GRANT: begin
        if (!holder_req || hold_expired) begin
          ptr_n  = pick_ptr;
          hold_n = HW'(1);
          if (pick_found) begin
            gnt_n     = ONE_BIT << pick_idx;
            idx_n     = pick_idx;
            preempt_n = holder_req;
          end else if (!holder_req) begin
            state_n = IDLE;
            gnt_n   = '0;
            idx_n   = '0;
            valid_n = 1'b0;
            hold_n  = '0;
          end
        end else if ((MAX_HOLD != 0) || (hold_cnt != {HW{1'b1}})) begin
          hold_n = hold_cnt + HW'(1);
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ptr       <= '0;
      hold_cnt  <= '0;
      gnt       <= '0;
      gnt_idx   <= '0;
      gnt_valid <= 1'b0;
      preempt   <= 1'b0;
    end else begin
      state     <= state_n;
      ptr       <= ptr_n;
      hold_cnt  <= hold_n;
      gnt       <= gnt_n;
      gnt_idx   <= idx_n;
      gnt_valid <= valid_n;
      preempt   <= preempt_n;
    end
  end

endmodule

// File: tb/tb_rr_arbiter_8.sv
// Self-checking bench for rr_arbiter_8: reference model compared every cycle
// plus directed vectors with hand-computed grants.
module tb_rr_arbiter_8;

  localparam int MAXH = 4;

  logic       clk;
  logic       rst_n;
  logic [7:0] req;
  logic [7:0] gnt;
  logic [2:0] gnt_idx;
  logic       gnt_valid;
  logic       preempt;

  int n_checks;
  int n_fail;

  rr_arbiter_8 #(.MAX_HOLD(MAXH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .gnt       (gnt),
    .gnt_idx   (gnt_idx),
    .gnt_valid (gnt_valid),
    .preempt   (preempt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: who holds the resource, for how long, and where the
  // round-robin scan starts next.
  int m_holder;
  int m_ptr;
  int m_cnt;
  bit m_pre;

  function automatic int pick(input logic [7:0] r, input int start, input int skip);
    for (int k = 0; k < 8; k++) begin
      int i;
      i = (start + k) % 8;
      if (i != skip && r[i]) return i;
    end
    return -1;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_holder <= -1;
      m_ptr    <= 0;
      m_cnt    <= 0;
      m_pre    <= 1'b0;
    end else begin
      m_pre <= 1'b0;
      if (m_holder < 0) begin
        m_holder <= pick(req, m_ptr, -1);
        m_cnt    <= (pick(req, m_ptr, -1) >= 0) ? 1 : 0;
      end else if (!req[m_holder]) begin
        m_ptr    <= (m_holder + 1) % 8;
        m_holder <= pick(req, (m_holder + 1) % 8, m_holder);
        m_cnt    <= (pick(req, (m_holder + 1) % 8, m_holder) >= 0) ? 1 : 0;
      end else if (MAXH == 0 || m_cnt < MAXH) begin
        m_cnt <= m_cnt + 1;
      end else begin
        m_ptr <= (m_holder + 1) % 8;
        m_cnt <= 1;
        if (pick(req, (m_holder + 1) % 8, m_holder) >= 0) begin
          m_holder <= pick(req, (m_holder + 1) % 8, m_holder);
          m_pre    <= 1'b1;
        end
      end
    end
  end

  always @(negedge clk) begin
    logic [7:0] exp_gnt;
    logic [2:0] exp_idx;
    exp_gnt = (m_holder >= 0) ? (8'd1 << m_holder) : 8'd0;
    exp_idx = (m_holder >= 0) ? 3'(m_holder) : 3'd0;
    n_checks++;
    if (gnt !== exp_gnt || gnt_idx !== exp_idx ||
        gnt_valid !== (m_holder >= 0) || preempt !== m_pre) begin
      n_fail++;
      $display("[TB] FAIL model t=%0t: got gnt=%b idx=%0d valid=%b pre=%b, expected gnt=%b idx=%0d valid=%b pre=%b",
               $time, gnt, gnt_idx, gnt_valid, preempt,
               exp_gnt, exp_idx, (m_holder >= 0), m_pre);
    end
  end

  task automatic apply_stimulus(input logic [7:0] r, input int cycles);
    req = r;
    repeat (cycles) @(negedge clk);
    #1;
  endtask

  task automatic check_output(input string name, input logic [7:0] eg,
                              input logic [2:0] ei, input logic ev, input logic ep);
    n_checks++;
    if (gnt !== eg || gnt_idx !== ei || gnt_valid !== ev || preempt !== ep) begin
      n_fail++;
      $display("[TB] FAIL %s: got gnt=%b idx=%0d valid=%b pre=%b, expected gnt=%b idx=%0d valid=%b pre=%b",
               name, gnt, gnt_idx, gnt_valid, preempt, eg, ei, ev, ep);
    end
  endtask

  typedef struct {
    logic [7:0] r;
    logic [7:0] g;
    logic [2:0] i;
  } vec_t;

  vec_t vecs[17];

  logic [2:0] rot_idx[10];
  logic       rot_pre[10];

  initial begin
    n_checks = 0;
    n_fail   = 0;

    // Single requests, wrap of ptr, fairness between 0 and 7, back-to-back.
    vecs = '{
      '{8'h04, 8'h04, 3'd2}, '{8'h00, 8'h00, 3'd0}, '{8'h02, 8'h02, 3'd1},
      '{8'h00, 8'h00, 3'd0}, '{8'h80, 8'h80, 3'd7}, '{8'h00, 8'h00, 3'd0},
      '{8'h81, 8'h01, 3'd0}, '{8'h80, 8'h80, 3'd7}, '{8'h81, 8'h80, 3'd7},
      '{8'h01, 8'h01, 3'd0}, '{8'h81, 8'h01, 3'd0}, '{8'h80, 8'h80, 3'd7},
      '{8'h00, 8'h00, 3'd0}, '{8'h04, 8'h04, 3'd2}, '{8'h24, 8'h04, 3'd2},
      '{8'h20, 8'h20, 3'd5}, '{8'h00, 8'h00, 3'd0}
    };
    rot_idx = '{3'd0, 3'd0, 3'd0, 3'd0, 3'd1, 3'd1, 3'd1, 3'd1, 3'd0, 3'd0};
    rot_pre = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

    rst_n = 1'b0;
    req   = 8'hFF;
    repeat (2) @(negedge clk);
    #1;
    check_output("reset", 8'h00, 3'd0, 1'b0, 1'b0);

    rst_n = 1'b1;
    apply_stimulus(8'hFF, 1);
    check_output("first_grant", 8'h01, 3'd0, 1'b1, 1'b0);

    #2;
    rst_n = 1'b0;
    #1;
    check_output("async_reset", 8'h00, 3'd0, 1'b0, 1'b0);
    @(negedge clk);
    #1;
    rst_n = 1'b1;

    for (int k = 0; k < 17; k++) begin
      apply_stimulus(vecs[k].r, 1);
      check_output($sformatf("vec%0d", k), vecs[k].g, vecs[k].i,
                   vecs[k].g != 8'h00, 1'b0);
    end

    req = 8'h03;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      #1;
      check_output($sformatf("rotate%0d", c), 8'h01 << rot_idx[c], rot_idx[c],
                   1'b1, rot_pre[c]);
    end

    apply_stimulus(8'h00, 1);
    check_output("rotate_release", 8'h00, 3'd0, 1'b0, 1'b0);

    req = 8'h08;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      #1;
      check_output($sformatf("solo%0d", c), 8'h08, 3'd3, 1'b1, 1'b0);
    end

    apply_stimulus(8'h00, 2);
    check_output("final_idle", 8'h00, 3'd0, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
